// File: rtl/sobel_gradient_core.sv
// Sobel Gx/Gy gradient core: 3-stage pipeline producing a saturated L1 edge magnitude
// with raster border suppression and end-of-frame tagging. Define SOBEL_BIN_EN for thresholded output.
module sobel_gradient_core #(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int COL_SKIP = 2,
  parameter int ROW_SKIP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             win_valid,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] p3,
  input  logic [PIX_W-1:0] p4,
  input  logic [PIX_W-1:0] p5,
  input  logic [PIX_W-1:0] p6,
  input  logic [PIX_W-1:0] p7,
  input  logic [PIX_W-1:0] p8,
  input  logic [PIX_W-1:0] p9,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] edge_out,
  output logic             out_valid,
  output logic             out_border,
  output logic             out_eof
);

  localparam int GW = PIX_W + 3;
  localparam int AW = PIX_W + 2;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [GW-1:0] PIX_MAX  = GW'((1 << PIX_W) - 1);

  // (a + 2b + c) - (d + 2e + f); both weighted sums fit in PIX_W+2 bits, so GW never overflows.
  function automatic logic signed [GW-1:0] weighted_diff(
    input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b, input logic [PIX_W-1:0] c,
    input logic [PIX_W-1:0] d, input logic [PIX_W-1:0] e, input logic [PIX_W-1:0] f);
    logic [GW-1:0] pos;
    logic [GW-1:0] neg;
    pos = GW'(a) + (GW'(b) << 1) + GW'(c);
    neg = GW'(d) + (GW'(e) << 1) + GW'(f);
    return signed'(pos - neg);
  endfunction

  function automatic logic [AW-1:0] abs_mag(input logic signed [GW-1:0] v);
    logic signed [GW-1:0] m;
    m = (v < 0) ? -v : v;
    return m[AW-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] sat_pix(input logic [GW-1:0] s);
    return (s > PIX_MAX) ? {PIX_W{1'b1}} : s[PIX_W-1:0];
  endfunction

  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           w_col_tag;
  logic [RW-1:0]           w_row_tag;
  logic                    w_border_tag;
  logic                    w_eof_tag;
  logic                    w_unused_taps;

  logic                    r_vld_p1;
  logic signed [GW-1:0]    r_gx_p1;
  logic signed [GW-1:0]    r_gy_p1;
  logic                    r_border_p1;
  logic                    r_eof_p1;

  logic                    r_vld_p2;
  logic [AW-1:0]           r_ax_p2;
  logic [AW-1:0]           r_ay_p2;
  logic                    r_border_p2;
  logic                    r_eof_p2;

  logic [GW-1:0]           w_sum;
  logic [PIX_W-1:0]        w_sat;
  logic [PIX_W-1:0]        w_edge;

  // The centre tap never contributes to a Sobel kernel.
  assign w_unused_taps = ^{p5, thresh};

  // frame_start coincident with a window tags that window (0,0).
  assign w_col_tag    = frame_start ? '0 : r_col;
  assign w_row_tag    = frame_start ? '0 : r_row;
  assign w_border_tag = (w_row_tag < RW'(ROW_SKIP)) || (w_col_tag < CW'(COL_SKIP));
  assign w_eof_tag    = (w_row_tag == ROW_LAST) && (w_col_tag == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (win_valid) begin
      if (w_col_tag == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row_tag == ROW_LAST) ? '0 : w_row_tag + RW'(1);
      end else begin
        r_col <= w_col_tag + CW'(1);
        r_row <= w_row_tag;
      end
    end else if (frame_start) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // Stage 1: signed gradients and position tags
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= win_valid;
  end

  always_ff @(posedge clk) begin
    if (win_valid) begin
      r_gx_p1     <= weighted_diff(p3, p6, p9, p1, p4, p7);
      r_gy_p1     <= weighted_diff(p7, p8, p9, p1, p2, p3);
      r_border_p1 <= w_border_tag;
      r_eof_p1    <= w_eof_tag;
    end
  end

  // Stage 2: absolute values
  always_ff @(posedge clk) begin
    if (rst) r_vld_p2 <= 1'b0;
    else     r_vld_p2 <= r_vld_p1;
  end

  always_ff @(posedge clk) begin
    if (r_vld_p1) begin
      r_ax_p2     <= abs_mag(r_gx_p1);
      r_ay_p2     <= abs_mag(r_gy_p1);
      r_border_p2 <= r_border_p1;
      r_eof_p2    <= r_eof_p1;
    end
  end

`ifdef SOBEL_BIN_EN
  logic [PIX_W-1:0] r_thr_p1;
  logic [PIX_W-1:0] r_thr_p2;

  always_ff @(posedge clk) begin
    if (win_valid) r_thr_p1 <= thresh;
    if (r_vld_p1)  r_thr_p2 <= r_thr_p1;
  end
`endif

  assign w_sum = GW'(r_ax_p2) + GW'(r_ay_p2);
  assign w_sat = sat_pix(w_sum);

  always_comb begin
    w_edge = '0;
    if (!r_border_p2) begin
`ifdef SOBEL_BIN_EN
      w_edge = (w_sat >= r_thr_p2) ? {PIX_W{1'b1}} : '0;
`else
      w_edge = w_sat;
`endif
    end
  end

  // Stage 3: output registers, held between valid outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      edge_out   <= '0;
      out_border <= 1'b0;
      out_eof    <= 1'b0;
    end else begin
      out_valid <= r_vld_p2;
      if (r_vld_p2) begin
        edge_out   <= w_edge;
        out_border <= r_border_p2;
        out_eof    <= r_eof_p2;
      end
    end
  end

endmodule

// File: tb/tb_sobel_gradient_core.sv
// Scoreboard bench for sobel_gradient_core on an 8x6 frame; expected results come from a
// plain-arithmetic Sobel/raster model and are checked by an independent output monitor.
module tb_sobel_gradient_core;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int COL_SKIP = 2;
  localparam int ROW_SKIP = 2;
  localparam int NPIX = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             frame_start = 1'b0;
  logic             win_valid = 1'b0;
  logic [PIX_W-1:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0, p5 = '0;
  logic [PIX_W-1:0] p6 = '0, p7 = '0, p8 = '0, p9 = '0;
  logic [PIX_W-1:0] thresh = '0;
  logic [PIX_W-1:0] edge_out;
  logic             out_valid, out_border, out_eof;

  sobel_gradient_core #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .COL_SKIP(COL_SKIP), .ROW_SKIP(ROW_SKIP)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .win_valid(win_valid),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
    .thresh(thresh), .edge_out(edge_out), .out_valid(out_valid),
    .out_border(out_border), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int e_val;
    int border;
    int eof;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n = 0;
  int   taps[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per DUT output, flags outputs that never arrived.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      check("out_valid_missing", 0, 1);
      void'(sb.pop_front());
    end
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("latency_cycle", cyc, e.due);
        check("edge_out", int'(edge_out), e.e_val);
        check("out_border", int'(out_border), e.border);
        check("out_eof", int'(out_eof), e.eof);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit fs, input int thr);
    int   gx, gy, mag, row, col;
    exp_t e;
    frame_start = fs;
    win_valid   = 1'b1;
    p1 = 8'(taps[0]); p2 = 8'(taps[1]); p3 = 8'(taps[2]);
    p4 = 8'(taps[3]); p5 = 8'(taps[4]); p6 = 8'(taps[5]);
    p7 = 8'(taps[6]); p8 = 8'(taps[7]); p9 = 8'(taps[8]);
    thresh = 8'(thr);
    if (fs) n = 0;
    row = n / IMG_W;
    col = n % IMG_W;
    gx  = (taps[2] + 2 * taps[5] + taps[8]) - (taps[0] + 2 * taps[3] + taps[6]);
    gy  = (taps[6] + 2 * taps[7] + taps[8]) - (taps[0] + 2 * taps[1] + taps[2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
`ifdef SOBEL_BIN_EN
    mag = (mag >= thr) ? 255 : 0;
`endif
    e.border = (row < ROW_SKIP || col < COL_SKIP) ? 1 : 0;
    e.e_val  = e.border ? 0 : mag;
    e.eof    = (row == IMG_H - 1 && col == IMG_W - 1) ? 1 : 0;
    e.due    = cyc + 3;
    sb.push_back(e);
    n = (n + 1) % NPIX;
    step();
    win_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    win_valid = 1'b0;
    frame_start = 1'b0;
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    n = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_cols(input int l, input int r);
    for (int i = 0; i < 9; i++) taps[i] = (i % 3 == 0) ? l : ((i % 3 == 2) ? r : 0);
  endtask

  task automatic rand_taps();
    for (int i = 0; i < 9; i++) taps[i] = int'($urandom_range(0, 255));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_edge_out"}, int'(edge_out), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_border"}, int'(out_border), 0);
    check({tag, "_out_eof"}, int'(out_eof), 0);
  endtask

  initial begin
    int thr;
    do_reset();
    check_reset_state("reset");

    // frame_start alone, then a flat frame: all outputs zero
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n = 0;
    for (int i = 0; i < 9; i++) taps[i] = 100;
    for (int i = 0; i < NPIX; i++) send(1'b0, 0);

    // random frame with directed interior windows
    for (int i = 0; i < NPIX; i++) begin
      rand_taps();
      thr = 30 + 10 * int'($urandom_range(0, 2));
      case (i)
        28: set_cols(0, 255);
        29: set_cols(255, 0);
        30: begin set_cols(0, 10); thr = 50; end
        31: begin set_cols(0, 10); thr = 30; end
        36: begin set_cols(0, 10); thr = 40; end
        default: ;
      endcase
      send(i == 0, thr);
    end

    // window every other cycle for a full frame
    for (int i = 0; i < NPIX; i++) begin
      rand_taps();
      send(i == 0, int'($urandom_range(0, 255)));
      step();
    end

    // mid-frame reset with a strong edge just out and two windows in flight
    set_cols(0, 255);
    for (int i = 0; i < 33; i++) send(i == 0, 0);
    do_reset();
    check_reset_state("midreset");
    for (int i = 0; i < NPIX; i++) send(1'b0, 0);

    // frame_start coincident with a window at position (2,5)
    for (int i = 0; i < 21; i++) begin
      rand_taps();
      send(1'b0, int'($urandom_range(0, 255)));
    end
    for (int i = 0; i < NPIX; i++) begin
      rand_taps();
      if (i < 2) set_cols(255, 0);
      send(i == 0, int'($urandom_range(0, 255)));
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    step();
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
